// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: multicycle MIPS sequencer with memory handshake, watchdog and retire counter
module multicycle_control_fsm #(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter int MAX_WAIT = 16,
  parameter int WAIT_W = 8,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Opcode,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             IorD,
  output logic             IRWrite,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSrc,
  output logic             PCWrite,
  output logic             Branch,
  output logic             PCEn,
  output logic             IllegalOp,
  output logic             MemTimeout,
  output logic [CNT_W-1:0] InstrCount,
  output logic [3:0]       state_o
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4, MEMWR = 4'd5,
    EXEC = 4'd6, ALUWB = 4'd7, BRANCH = 4'd8, ADDIEX = 4'd9, ADDIWB = 4'd10, JUMP = 4'd11
  } state_t;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
  state_t state, state_n;
  logic [WAIT_W-1:0] cnt;
  logic rdy, mem_st, timeout, retire, illegal;
  assign rdy = mem_ready | ~MEM_HANDSHAKE;
  assign mem_st = state inside {FETCH, MEMRD, MEMWR};
  // rdy takes priority: a completing access on the last allowed cycle is not a timeout
  assign timeout = mem_st & ~rdy & (cnt == WAIT_W'(MAX_WAIT - 1));
  assign retire = (state inside {MEMWB, ALUWB, ADDIWB, BRANCH, JUMP}) | (state == MEMWR & rdy);
  assign illegal = state == DECODE & !(Opcode inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J});
  always_comb begin
    state_n = FETCH;
    case (state)
      FETCH:  state_n = rdy ? DECODE : FETCH;
      DECODE: state_n = (Opcode == OP_LW || Opcode == OP_SW) ? MEMADR :
                        Opcode == OP_R    ? EXEC   :
                        Opcode == OP_BEQ  ? BRANCH :
                        Opcode == OP_ADDI ? ADDIEX :
                        Opcode == OP_J    ? JUMP   : FETCH;
      MEMADR: state_n = Opcode == OP_SW ? MEMWR : MEMRD;
      MEMRD:  state_n = rdy ? MEMWB : timeout ? FETCH : MEMRD;
      MEMWR:  state_n = (rdy | timeout) ? FETCH : MEMWR;
      EXEC:   state_n = ALUWB;
      ADDIEX: state_n = ADDIWB;
      default: state_n = FETCH;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
      cnt <= '0;
      IllegalOp <= 1'b0;
      MemTimeout <= 1'b0;
      InstrCount <= '0;
    end else begin
      state <= state_n;
      cnt <= (state_n != state || timeout) ? '0 : (mem_st & ~rdy) ? cnt + WAIT_W'(1) : cnt;
      IllegalOp <= illegal;
      MemTimeout <= MemTimeout | timeout;
      InstrCount <= InstrCount + CNT_W'(retire);
    end
  end
  // write enables are qualified by reset so nothing commits while it is held low
  assign IorD = state inside {MEMRD, MEMWR};
  assign IRWrite = reset & state == FETCH & rdy;
  assign PCWrite = reset & ((state == FETCH & rdy) | state == JUMP);
  assign MemWrite = reset & state == MEMWR;
  assign RegWrite = reset & (state inside {MEMWB, ALUWB, ADDIWB});
  assign RegDst = state == ALUWB;
  assign MemtoReg = state == MEMWB;
  assign ALUSrcA = state inside {MEMADR, ADDIEX, EXEC, BRANCH};
  assign ALUSrcB = state == FETCH ? 2'b01 : state == DECODE ? 2'b11 :
                   (state inside {MEMADR, ADDIEX}) ? 2'b10 : 2'b00;
  assign ALUOp = state == EXEC ? 2'b10 : state == BRANCH ? 2'b01 : 2'b00;
  assign PCSrc = state == BRANCH ? 2'b01 : state == JUMP ? 2'b10 : 2'b00;
  assign Branch = state == BRANCH;
  assign PCEn = reset & (PCWrite | (Branch & Zero));
  assign state_o = state;
endmodule
